// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver with a 2-flop input synchronizer feeding a first-word-fall-through byte FIFO.
module uart_rx_fifo #(
  parameter int fifo_log2 = 4,
  parameter int min_scaler = 4
) (
  input  logic                 i_clk,
  input  logic                 i_nrst,
  input  logic [15:0]          i_scaler,
  input  logic                 i_rx,
  output logic [7:0]           o_rdata,
  output logic                 o_rvalid,
  input  logic                 i_rready,
  output logic                 o_frame_err,
  output logic                 o_overflow,
  input  logic                 i_clr,
  output logic [fifo_log2:0]   o_count
);
  localparam int depth = 2 ** fifo_log2;
  localparam int aw = fifo_log2;
  localparam int cw = fifo_log2 + 1;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
  state_t state_q, state_d;
  logic sync_q, rx_s_q;
  logic [15:0] cnt_q, cnt_d, scl_q, scl_d, eff;
  logic [2:0] idx_q, idx_d;
  logic [7:0] shift_q, shift_d;
  logic push_q, push_d, ferr_q, ferr_d, ovf_q, ovf_d;
  logic [aw-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [cw-1:0] count_q, count_d;
  logic [7:0] mem_q [depth];
  logic tick, pop, wr;
  assign eff = (i_scaler < 16'(min_scaler)) ? 16'(min_scaler) : i_scaler;
  assign tick = cnt_q == 16'd1;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q - 16'd1;
    scl_d = scl_q;
    idx_d = idx_q;
    shift_d = shift_q;
    push_d = 1'b0;
    ferr_d = 1'b0;
    case (state_q)
      IDLE: if (!rx_s_q) begin
        state_d = START;
        scl_d = eff;
        cnt_d = eff >> 1;
      end
      START: if (tick) begin
        state_d = rx_s_q ? IDLE : DATA;
        cnt_d = scl_q;
        idx_d = 3'd0;
      end
      DATA: if (tick) begin
        shift_d[idx_q] = rx_s_q;
        cnt_d = scl_q;
        idx_d = idx_q + 3'd1;
        state_d = (idx_q == 3'd7) ? STOP : DATA;
      end
      STOP: if (tick) begin
        state_d = rx_s_q ? IDLE : WAIT_HIGH;
        push_d = rx_s_q;
        ferr_d = !rx_s_q;
      end
      WAIT_HIGH: state_d = rx_s_q ? IDLE : WAIT_HIGH;
      default: state_d = IDLE;
    endcase
  end
  // a push into a full FIFO only lands when the head leaves in the same cycle; flush beats both
  assign pop = o_rvalid & i_rready;
  assign wr = push_q & ((count_q != cw'(depth)) | pop) & ~i_clr;
  always_comb begin
    wp_d = i_clr ? '0 : wp_q + aw'(wr);
    rp_d = i_clr ? '0 : rp_q + aw'(pop);
    count_d = i_clr ? '0 : count_q + cw'(wr) - cw'(pop);
    ovf_d = ~i_clr & (ovf_q | (push_q & ~wr));
  end
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q <= IDLE;
      sync_q <= 1'b1;
      rx_s_q <= 1'b1;
      cnt_q <= '0;
      scl_q <= '0;
      idx_q <= '0;
      shift_q <= '0;
      push_q <= 1'b0;
      ferr_q <= 1'b0;
      ovf_q <= 1'b0;
      wp_q <= '0;
      rp_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      sync_q <= i_rx;
      rx_s_q <= sync_q;
      cnt_q <= cnt_d;
      scl_q <= scl_d;
      idx_q <= idx_d;
      shift_q <= shift_d;
      push_q <= push_d;
      ferr_q <= ferr_d;
      ovf_q <= ovf_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge i_clk) begin
    if (wr) mem_q[wp_q] <= shift_q;
  end
  assign o_rvalid = count_q != '0;
  assign o_rdata = o_rvalid ? mem_q[rp_q] : 8'h00;
  assign o_count = count_q;
  assign o_frame_err = ferr_q;
  assign o_overflow = ovf_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: table-driven frames, corner-case sequences and random traffic against a queue model of the receiver FIFO.
module tb_uart_rx_fifo;
  localparam int lg = 4;
  localparam int depth = 16;
  typedef struct {
    logic [7:0] data;
    int         scl;
    bit         stop_ok;
    int         exp_ferr;
    int         exp_cnt;
  } vec_t;
  logic clk = 1'b0, nrst = 1'b0, rx = 1'b1, rready = 1'b0, clr = 1'b0;
  logic [15:0] scaler = 16'd16;
  logic [7:0] rdata;
  logic rvalid, ferr, ovf;
  logic [lg:0] count;
  int n_tests = 0, n_fail = 0, ferr_cnt = 0;
  logic [7:0] mq[$];
  bit movf = 1'b0;

  uart_rx_fifo #(.fifo_log2(lg), .min_scaler(4)) dut (
    .i_clk(clk), .i_nrst(nrst), .i_scaler(scaler), .i_rx(rx),
    .o_rdata(rdata), .o_rvalid(rvalid), .i_rready(rready),
    .o_frame_err(ferr), .o_overflow(ovf), .i_clr(clr), .o_count(count)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (ferr === 1'b1) ferr_cnt++;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_fifo(input string tag);
    chk({tag, " count"}, 32'(count), mq.size());
    chk({tag, " rvalid"}, 32'(rvalid), 32'(mq.size() != 0));
    if (mq.size() != 0) chk({tag, " rdata"}, 32'(rdata), 32'(mq[0]));
    chk({tag, " overflow"}, 32'(ovf), 32'(movf));
  endtask

  function automatic int eff_of(input int s);
    return s < 4 ? 4 : s;
  endfunction

  task automatic model_push(input logic [7:0] b);
    if (mq.size() < depth) mq.push_back(b);
    else movf = 1'b1;
  endtask

  // at_push: 0 none, 1 assert i_rready, 2 assert i_clr on the cycle the received byte is written
  task automatic send_frame(input logic [7:0] b, input int s, input bit stop_ok, input bit hold,
                            input bit chk_lat, input int at_push, input int rst_at);
    int e, v;
    logic [9:0] fr;
    e = eff_of(s);
    v = 3 + e / 2 + 9 * e;
    fr = {stop_ok, b, 1'b0};
    scaler = 16'(s);
    for (int n = 0; n < 10 * e + 3; n++) begin
      if (rst_at != 0 && n == rst_at) begin
        nrst = 1'b0;
        rx = 1'b1;
        @(negedge clk);
        chk("rst rvalid", 32'(rvalid), 0);
        chk("rst count", 32'(count), 0);
        chk("rst rdata", 32'(rdata), 0);
        chk("rst frame_err", 32'(ferr), 0);
        chk("rst overflow", 32'(ovf), 0);
        nrst = 1'b1;
        repeat (3) @(negedge clk);
        return;
      end
      if (chk_lat && n == v) chk("latency rvalid early", 32'(rvalid), 0);
      if (chk_lat && n == v + 1) begin
        chk("latency rvalid", 32'(rvalid), 1);
        chk("latency rdata", 32'(rdata), 32'(b));
      end
      rready = (at_push == 1 && n == v);
      clr = (at_push == 2 && n == v);
      if (n == 3 * e) scaler = 16'($urandom);
      rx = n < 10 * e ? fr[n / e] : !hold;
      @(negedge clk);
    end
    rready = 1'b0;
    clr = 1'b0;
  endtask

  task automatic idle_cyc(input bit r, input bit c);
    chk_fifo("idle");
    rready = r;
    clr = c;
    @(negedge clk);
    if (c) begin
      mq.delete();
      movf = 1'b0;
    end else if (r && mq.size() != 0) void'(mq.pop_front());
    rready = 1'b0;
    clr = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 300 && mq.size() != 0; k++) idle_cyc(1'($urandom_range(0, 1)), 1'b0);
    chk("drain empty count", 32'(count), 0);
    chk_fifo("drained");
  endtask

  initial begin
    vec_t vt[7];
    int f0;
    logic [7:0] b;
    int s;
    bit ok;
    vt[0] = '{8'h55, 16, 1'b1, 0, 1};
    vt[1] = '{8'hA3, 16, 1'b0, 1, 1};
    vt[2] = '{8'h00, 8,  1'b1, 0, 2};
    vt[3] = '{8'hFF, 2,  1'b1, 0, 3};
    vt[4] = '{8'h81, 5,  1'b0, 1, 3};
    vt[5] = '{8'h3C, 7,  1'b1, 0, 4};
    vt[6] = '{8'hC9, 33, 1'b1, 0, 5};
    repeat (3) @(negedge clk);
    chk("reset rvalid", 32'(rvalid), 0);
    chk("reset count", 32'(count), 0);
    chk("reset rdata", 32'(rdata), 0);
    chk("reset frame_err", 32'(ferr), 0);
    chk("reset overflow", 32'(ovf), 0);
    nrst = 1'b1;
    repeat (3) @(negedge clk);
    chk_fifo("post reset");
    // 0x55 at scaler 16: visible exactly on edge 155 after the falling edge
    f0 = ferr_cnt;
    send_frame(8'h55, 16, 1'b1, 1'b0, 1'b1, 0, 0);
    mq.push_back(8'h55);
    chk("basic frame_err", 32'(ferr_cnt - f0), 0);
    chk_fifo("basic");
    drain();
    for (int i = 0; i < 7; i++) begin
      f0 = ferr_cnt;
      send_frame(vt[i].data, vt[i].scl, vt[i].stop_ok, 1'b0, 1'b0, 0, 0);
      chk($sformatf("vec%0d frame_err", i), 32'(ferr_cnt - f0), 32'(vt[i].exp_ferr));
      chk($sformatf("vec%0d count", i), 32'(count), 32'(vt[i].exp_cnt));
      if (vt[i].stop_ok) mq.push_back(vt[i].data);
    end
    drain();
    // bad stop followed by a long break: one pulse only
    f0 = ferr_cnt;
    send_frame(8'hA3, 16, 1'b0, 1'b1, 1'b0, 0, 0);
    repeat (1600) @(negedge clk);
    rx = 1'b1;
    repeat (4) @(negedge clk);
    chk("break frame_err", 32'(ferr_cnt - f0), 1);
    chk_fifo("break");
    send_frame(8'h12, 16, 1'b1, 1'b0, 1'b1, 0, 0);
    mq.push_back(8'h12);
    chk_fifo("after break");
    drain();
    // short low glitch
    scaler = 16'd16;
    f0 = ferr_cnt;
    rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    chk("glitch frame_err", 32'(ferr_cnt - f0), 0);
    chk_fifo("glitch");
    send_frame(8'h5A, 16, 1'b1, 1'b0, 1'b1, 0, 0);
    mq.push_back(8'h5A);
    drain();
    // overflow with 17 bytes
    for (int i = 0; i < 17; i++) begin
      send_frame(8'(i), 4, 1'b1, 1'b0, 1'b0, 0, 0);
      model_push(8'(i));
    end
    chk("ovf count", 32'(count), 16);
    chk("ovf flag", 32'(ovf), 1);
    drain();
    chk("ovf sticky", 32'(ovf), 1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    movf = 1'b0;
    chk("clr overflow", 32'(ovf), 0);
    // full FIFO with a pop on the push cycle
    for (int i = 0; i < 16; i++) begin
      send_frame(8'h20 + 8'(i), 4, 1'b1, 1'b0, 1'b0, 0, 0);
      model_push(8'h20 + 8'(i));
    end
    send_frame(8'h30, 4, 1'b1, 1'b0, 1'b0, 1, 0);
    void'(mq.pop_front());
    mq.push_back(8'h30);
    chk("full pop count", 32'(count), 16);
    chk("full pop overflow", 32'(ovf), 0);
    chk_fifo("full pop");
    // flush on the push cycle loses the byte silently
    send_frame(8'h31, 4, 1'b1, 1'b0, 1'b0, 2, 0);
    mq.delete();
    movf = 1'b0;
    chk("clr push count", 32'(count), 0);
    chk("clr push overflow", 32'(ovf), 0);
    for (int i = 0; i < 17; i++) begin
      send_frame(8'h40 + 8'(i), 3, 1'b1, 1'b0, 1'b0, 0, 0);
      model_push(8'h40 + 8'(i));
    end
    chk_fifo("refill");
    // reset in the middle of a frame at the clamped scaler
    send_frame(8'h7E, 2, 1'b1, 1'b0, 1'b0, 0, 12);
    mq.delete();
    movf = 1'b0;
    chk_fifo("after reset");
    send_frame(8'h81, 2, 1'b1, 1'b0, 1'b1, 0, 0);
    mq.push_back(8'h81);
    chk_fifo("after reset frame");
    drain();
    for (int it = 0; it < 60; it++) begin
      b = 8'($urandom);
      s = $urandom_range(0, 12);
      ok = ($urandom_range(0, 4) != 0);
      f0 = ferr_cnt;
      send_frame(b, s, ok, 1'b0, 1'b0, 0, 0);
      if (ok) model_push(b);
      chk("rnd frame_err", 32'(ferr_cnt - f0), 32'(!ok));
      chk_fifo("rnd");
      repeat ($urandom_range(0, 4)) idle_cyc($urandom_range(0, 3) == 0, $urandom_range(0, 29) == 0);
    end
    drain();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter fifo_log2, default 4, meaning FIFO depth = 2**fifo_log2 bytes (allowed range 1..8).
REQ-002 Parameter min_scaler, default 4, meaning the smallest clocks-per-bit value honoured.
REQ-003 i_clk  input  1  single clock; all state on rising edge.
REQ-004 i_nrst  input  1  reset, asynchronous and active-low.
REQ-005 i_scaler  input  16  clocks per serial bit period.
REQ-006 i_rx  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-007 o_rdata  output  8  byte at FIFO head (first-word-fall-through).
REQ-008 o_rvalid  output  1  FIFO not empty.
REQ-009 i_rready  input  1  consumer accepts head byte when o_rvalid=1.
REQ-010 o_frame_err  output  1  one-cycle pulse on bad stop bit.
REQ-011 o_overflow  output  1  sticky; a received byte was dropped because the FIFO was full.
REQ-012 i_clr  input  1  synchronous flush of the FIFO and clear of o_overflow.
REQ-013 o_count  output  fifo_log2+1  current FIFO occupancy.

Function
REQ-014 i_rx SHALL pass through a 2-flop synchronizer (both flops reset to 1) before any use; "rx_s" denotes the synchronized value.
REQ-015 Effective scaler SHALL be max(i_scaler, min_scaler), latched on start detection; changes to i_scaler mid-frame SHALL have no effect until the next frame.
REQ-016 FSM states: IDLE, START, DATA, STOP, WAIT_HIGH; reset state IDLE.
REQ-017 IDLE: a 1->0 transition of rx_s SHALL go to START with bit counter = scaler/2 (floor).
REQ-018 START: when the counter reaches 0, rx_s is sampled; 0 -> DATA (counter = scaler, bit index = 0); 1 -> IDLE (glitch, no output, no error).
REQ-019 DATA: every scaler clocks one bit SHALL be sampled into shift register position bit index; after bit index 7 -> STOP with counter = scaler.
REQ-020 STOP: on counter 0, rx_s=1 SHALL push the byte and go to IDLE; rx_s=0 SHALL pulse o_frame_err for 1 cycle, drop the byte and go to WAIT_HIGH.
REQ-021 WAIT_HIGH: remain until rx_s=1, then go to IDLE; a break (line held low) SHALL produce exactly one o_frame_err.
REQ-022 Push-to-visible latency: o_rvalid/o_rdata SHALL update on the clock edge after the stop sample.
REQ-023 Pop occurs on any cycle with o_rvalid=1 and i_rready=1; i_rready with empty FIFO SHALL be ignored.
REQ-024 Push when full SHALL be accepted only if a pop occurs in the same cycle; otherwise the byte is dropped and o_overflow set.
REQ-025 Simultaneous push and pop SHALL leave o_count unchanged; pointers wrap modulo depth.
REQ-026 i_clr SHALL take priority over push and pop in the same cycle: FIFO empties, o_overflow clears, the concurrent byte is lost without setting o_overflow; FSM is unaffected.

Reset
REQ-027 While i_nrst=0: FSM IDLE, synchronizer flops 1, FIFO pointers 0, o_rvalid=0, o_count=0, o_rdata=0x00, o_frame_err=0, o_overflow=0.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no push and no error; after release a new frame SHALL be received normally after the line is seen high then low.

Verification
REQ-029 scaler=16, send 0x55 with falling edge at cycle 0 -> o_rvalid=1, o_rdata=0x55 at cycle 155; o_count=1; no frame_err.
REQ-030 scaler=16, send 0xA3 with stop bit driven low -> o_frame_err pulse of exactly 1 cycle at stop sample, no push; line held low 100 further bit times -> no second pulse; next valid 0x12 received correctly.
REQ-031 fifo_log2=4, i_rready=0, send 17 bytes 0x00..0x10 -> o_count=16, o_overflow=1 after 17th byte; pop all -> 0x00..0x0F in order, 0x10 absent.
REQ-032 FIFO full with i_rready=1 at the cycle of a push -> o_count stays 16, o_overflow stays 0, new byte appended at tail.
REQ-033 0.3-bit low glitch on i_rx (scaler=16, 5 clocks low) -> FSM returns to IDLE, no push, no error.
REQ-034 i_scaler=2 -> bit period behaves as 4 clocks; i_nrst pulsed low during DATA of byte 0x7E -> outputs at reset values, following byte 0x81 received intact.
